// File: rtl/aes_kexp_seq.sv
// Iterative AES-128/192/256 key expansion: one round-key word per clock into
// a flop-based buffer, with a registered read port for the cipher datapath.
module aes_kexp_seq #(
  parameter int NB     = 4,
  parameter int NK_MAX = 8,
  parameter int AW     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [32*NK_MAX-1:0]  key,
  input  logic [7:0]            SBox [0:255],
  input  logic [7:0]            RCon [0:15],
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  valid,
  output logic [3:0]            nr,
  input  logic [AW-1:0]         rd_addr,
  output logic [31:0]           rd_data
);

  localparam int DEPTH = NB * (NK_MAX + 7);
  localparam int KW    = $clog2(NK_MAX);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state, state_nx;

  logic [3:0]    nk_q;
  logic [AW:0]   t_q;
  logic [AW-1:0] idx;
  logic [KW-1:0] j;
  logic [3:0]    r;
  logic [3:0]    nr_q;
  logic [31:0]   win [0:NK_MAX-1];
  logic [31:0]   mem [0:DEPTH-1];

  logic [3:0]    nk_sel, nr_sel, nr_cur;
  logic [AW:0]   t_sel;
  logic [KW-1:0] kl;
  logic [31:0]   x, rot, sub_in, sub_out, fw, neww;
  logic          load, we, is_last;

  always_comb begin
    nk_sel  = 4'd4 + {1'b0, mode, 1'b0};
    nr_sel  = nk_sel + 4'd6;
    t_sel   = (AW+1)'(NB * (int'(nr_sel) + 1));
    nr_cur  = nk_q + 4'd6;
    kl      = KW'(nk_q - 4'd1);
    load    = (state == IDLE) && start && (mode != 2'd3);
    we      = (state == EXPAND);
    is_last = ({1'b0, idx} == (t_q - 1'b1));
    // x is w[idx-1] (newest in window), win[0] is w[idx-Nk]
    x       = win[kl];
    rot     = {x[23:0], x[31:24]};
    sub_in  = (j == '0) ? rot : x;
    sub_out = {SBox[sub_in[31:24]], SBox[sub_in[23:16]],
               SBox[sub_in[15:8]],  SBox[sub_in[7:0]]};
    if (j == '0)
      fw = sub_out ^ {RCon[r], 24'h0};
    else if ((nk_q == 4'd8) && (j == KW'(4)))
      fw = sub_out;
    else
      fw = x;
    neww = win[0] ^ fw;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = EXPAND;
      EXPAND:  if (is_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Buffer and shift window carry no reset; writes are suppressed while rst is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (load) begin
        for (int unsigned k = 0; k < NK_MAX; k++) begin
          win[k] <= key[32*(NK_MAX-k)-1 -: 32];
          if (k < 32'(nk_sel)) mem[k] <= key[32*(NK_MAX-k)-1 -: 32];
        end
      end else if (we) begin
        mem[idx] <= neww;
        for (int unsigned k = 0; k < NK_MAX - 1; k++)
          if (k < 32'(kl)) win[k] <= win[k+1];
        for (int unsigned k = 0; k < NK_MAX; k++)
          if (k == 32'(kl)) win[k] <= neww;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      valid   <= 1'b0;
      nr_q    <= '0;
      rd_data <= '0;
      nk_q    <= 4'd4;
      t_q     <= '0;
      idx     <= '0;
      j       <= '0;
      r       <= 4'd1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && mode == 2'd3) begin
            err <= 1'b1;
          end else if (load) begin
            nk_q  <= nk_sel;
            t_q   <= t_sel;
            idx   <= AW'(nk_sel);
            j     <= '0;
            r     <= 4'd1;
            valid <= 1'b0;
            nr_q  <= '0;
            busy  <= 1'b1;
          end
        end
        EXPAND: begin
          idx <= idx + 1'b1;
          j   <= (j == kl) ? '0 : j + 1'b1;
          if (j == '0) r <= r + 1'b1;
          if (is_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            valid <= 1'b1;
            nr_q  <= nr_cur;
          end
        end
        default: ;
      endcase
      if (valid && ({1'b0, rd_addr} < t_q)) rd_data <= mem[rd_addr];
      else                                  rd_data <= '0;
    end
  end

  assign nr = nr_q;

endmodule

// File: tb/tb_aes_kexp_seq.sv
// Bench for aes_kexp_seq: FIPS-197 key schedules, err/ignore/reset behaviour,
// read-port results checked through an expected-value queue.
module tb_aes_kexp_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  mode;
  logic [255:0] key;
  logic [7:0]  sbox [0:255];
  logic [7:0]  rcon [0:15];
  logic        busy, done, err, valid;
  logic [3:0]  nr;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] ew [0:59];

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] e;
  } rd_t;
  rd_t sbq [$];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_kexp_seq #(.NB(4), .NK_MAX(8), .AW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key),
    .SBox(sbox), .RCon(rcon), .busy(busy), .done(done), .err(err),
    .valid(valid), .nr(nr), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] v = b;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
    return v;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Textbook schedule using i mod Nk
  task automatic expand_model(input logic [255:0] k, input int nk);
    logic [31:0] t;
    for (int i = 0; i < 60; i++) ew[i] = 32'h0;
    for (int i = 0; i < nk; i++) ew[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = ew[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon[i/nk], 24'h0};
      else if (nk > 6 && i % nk == 4)
        t = subw(t);
      ew[i] = ew[i-nk] ^ t;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the registered result is checked at the following negedge.
  task automatic rd_word(input int a, input logic [31:0] e);
    rd_t it;
    rd_addr = 6'(a);
    sbq.push_back('{a: 6'(a), e: e});
    @(negedge clk);
    it = sbq.pop_front();
    check($sformatf("rd[%0d]", it.a), rd_data, it.e);
  endtask

  task automatic run(input logic [1:0] m, input logic [255:0] k, input bit poke);
    int nk, t, cnt, vbad;
    nk = 4 + 2*int'(m);
    t  = 4*(nk + 7);
    expand_model(k, nk);
    @(negedge clk);
    start = 1'b1; mode = m; key = k;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; vbad = 0;
    while (busy === 1'b1 && cnt < 200) begin
      if (valid !== 1'b0) vbad++;
      cnt++;
      start = poke && (cnt == 10);
      mode  = (poke && cnt == 10) ? 2'd0 : m;
      @(negedge clk);
    end
    start = 1'b0; mode = m;
    check($sformatf("busy_cycles_m%0d", m), cnt, t - nk);
    check("valid_while_busy", vbad, 0);
    check("done_hi", done, 1);
    check("valid_hi", valid, 1);
    check("nr", nr, nk + 6);
    rd_word(t - 1, ew[t-1]);
    check("done_one_cycle", done, 0);
    for (int i = 0; i < t; i++) rd_word(i, ew[i]);
    if (t < 64) rd_word(t, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] inv, rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon[0] = 8'h8d;
    rc = 8'h01;
    for (int i = 1; i < 16; i++) begin
      rcon[i] = rc;
      rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
    end

    rst = 1'b0; start = 1'b0; mode = 2'd0; key = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", valid, 0);
    check("rst_nr", nr, 0);
    check("rst_rd_data", rd_data, 0);
    rd_word(0, 32'h0);

    run(2'd0, K128, 1'b0);
    rd_word(4, 32'ha0fafe17);
    rd_word(43, 32'hb6630ca6);
    rd_word(44, 32'h0);

    // start re-asserted mid-run must not restart (cycle count unchanged)
    run(2'd1, K192, 1'b1);
    rd_word(6, 32'hfe0c91f7);
    rd_word(51, 32'h01002202);

    run(2'd2, K256, 1'b0);
    rd_word(8, 32'h9ba35411);
    rd_word(12, 32'ha8b09c1a);
    rd_word(59, 32'h706c631e);

    start = 1'b1; mode = 2'd3;
    @(negedge clk);
    start = 1'b0; mode = 2'd0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_valid_kept", valid, 1);
    check("err_nr_kept", nr, 14);
    @(negedge clk);
    check("err_one_cycle", err, 0);
    check("err_no_start", busy, 0);
    rd_word(59, 32'h706c631e);

    start = 1'b1; mode = 2'd2; key = K256;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_nr", nr, 0);
    check("mid_rst_done", done, 0);
    rd_word(0, 32'h0);
    check("idle_valid", valid, 0);

    run(2'd0, K128, 1'b0);
    rd_word(4, 32'ha0fafe17);
    rd_word(43, 32'hb6630ca6);
    rd_word(50, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
